// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU.
// Covers opcodes, register/ALU control codes, sequencer states and opcode decode.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDX  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MOVZ = 4'h4;
  localparam logic [3:0] OP_CLR  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] R_CLR  = 4'd0;
  localparam logic [3:0] R_LOAD = 4'd1;
  localparam logic [3:0] R_HOLD = 4'd2;
  localparam logic [3:0] R_SHR  = 4'd3;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSY = 4'd2;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  typedef struct packed {
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tz;
    logic [3:0] tula;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{tx: R_HOLD, ty: R_HOLD, tz: R_HOLD, tula: ALU_ADD};

  // Control word for one instruction; anything not listed behaves as NOP.
  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OP_LDX:  c.tx = R_LOAD;
      OP_ADD:  begin c.tula = ALU_ADD; c.ty = R_LOAD; end
      OP_SUB:  begin c.tula = ALU_SUB; c.ty = R_LOAD; end
      OP_MOVZ: c.tz = R_LOAD;
      OP_CLR:  begin c.tx = R_CLR; c.ty = R_CLR; c.tz = R_CLR; end
      OP_SHR:  c.ty = R_SHR;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// 4-bit program counter with clear > load > increment priority; wraps modulo 16.
module pc_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       inc,
  input  logic [3:0] din,
  output logic [3:0] pc
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= '0;
    else if (clr)  pc <= '0;
    else if (load) pc <= din;
    else if (inc)  pc <= pc + 4'd1;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec sequencer: owns the pc, handshakes with program
// memory and emits one-cycle register/ALU control words in EXEC.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] mem_addr,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic [3:0] mem_op,
  input  logic [3:0] mem_data,
  input  logic       ula_zero,
  output logic [3:0] Tx,
  output logic [3:0] Ty,
  output logic [3:0] Tz,
  output logic [3:0] Tula,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  state_t     state, next_state;
  logic [3:0] op_q, data_q;
  logic       pc_clr, pc_load, pc_inc;
  ctrl_t      ctrl_q;

  pc_counter u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pc_clr),
    .load  (pc_load),
    .inc   (pc_inc),
    .din   (data_q),
    .pc    (mem_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    next_state = state;
    pc_clr     = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      IDLE, HALT: if (start) begin
        next_state = FETCH;
        pc_clr     = 1'b1;
      end
      FETCH:  if (mem_ack) next_state = DECODE;
      DECODE: next_state = EXEC;
      EXEC: begin
        if (op_q == OP_HALT) begin
          next_state = HALT;
        end else begin
          next_state = FETCH;
          // Branch targets land on mem_addr in the very next FETCH cycle.
          if (op_q == OP_JMP || (op_q == OP_JZ && ula_zero)) pc_load = 1'b1;
          else                                               pc_inc  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state / latched opcode so they line up with the state.
  // NOTE: the instruction latch is reset like any control register; it is not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      data_q  <= '0;
      ctrl_q  <= CTRL_IDLE;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (state == FETCH && mem_ack) begin
        op_q   <= mem_op;
        data_q <= mem_data;
      end
      ctrl_q  <= (state == DECODE) ? decode(op_q) : CTRL_IDLE;
      illegal <= (state == DECODE) && is_illegal(op_q);
      mem_req <= (next_state == FETCH);
      busy    <= next_state inside {FETCH, DECODE, EXEC};
      halted  <= (next_state == HALT);
    end
  end

  assign Tx   = ctrl_q.tx;
  assign Ty   = ctrl_q.ty;
  assign Tz   = ctrl_q.tz;
  assign Tula = ctrl_q.tula;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: timing of control words, ack stalls,
// jumps/wrap, illegal opcodes and asynchronous reset mid-handshake.
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       ula_zero = 1'b0;
  logic       mem_ack, mem_req, busy, halted, illegal;
  logic [3:0] mem_addr, mem_op, mem_data, Tx, Ty, Tz, Tula;

  logic [7:0] prog [16];
  int         ack_delay = 0;
  int         wait_cnt;
  int         vectors = 0;
  int         miscompares = 0;

  instr_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_op   (mem_op),
    .mem_data (mem_data),
    .ula_zero (ula_zero),
    .Tx       (Tx),
    .Ty       (Ty),
    .Tz       (Tz),
    .Tula     (Tula),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // Memory model: acks after ack_delay cycles of an outstanding request.
  assign mem_ack  = mem_req && (wait_cnt >= ack_delay);
  assign mem_op   = prog[mem_addr][7:4];
  assign mem_data = prog[mem_addr][3:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_tx"}, Tx, R_HOLD);
    check({tag, "_ty"}, Ty, R_HOLD);
    check({tag, "_tz"}, Tz, R_HOLD);
    check({tag, "_tula"}, Tula, ALU_ADD);
  endtask

  task automatic wait_halted(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    check("halt_reached", {3'b000, halted}, 4'h1);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  initial begin
    clear_prog();
    prog[0] = 8'h13; prog[1] = 8'h20; prog[2] = 8'h40; prog[3] = 8'hF0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", mem_addr, 4'h0);
    check("rst_req", {3'b000, mem_req}, 4'h0);
    check("rst_busy", {3'b000, busy}, 4'h0);
    check("rst_halted", {3'b000, halted}, 4'h0);
    check("rst_illegal", {3'b000, illegal}, 4'h0);
    check_hold("rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", {3'b000, busy}, 4'h0);

    // {LDX 3, ADD, MOVZ, HALT} with same-cycle ack
    start = 1'b1; tick(); start = 1'b0;                    // cycle 1
    check("c1_req", {3'b000, mem_req}, 4'h1);
    check("c1_addr", mem_addr, 4'h0);
    check("c1_busy", {3'b000, busy}, 4'h1);
    tick();                                                // cycle 2
    check("c2_req_drop", {3'b000, mem_req}, 4'h0);
    check("c2_tx", Tx, R_HOLD);
    tick();                                                // cycle 3
    check("c3_tx", Tx, R_LOAD);
    check("c3_ty", Ty, R_HOLD);
    tick();                                                // cycle 4
    check("c4_tx", Tx, R_HOLD);
    check("c4_addr", mem_addr, 4'h1);
    repeat (2) tick();                                     // cycle 6
    check("c6_ty", Ty, R_LOAD);
    check("c6_tula", Tula, ALU_ADD);
    check("c6_tx", Tx, R_HOLD);
    repeat (3) tick();                                     // cycle 9
    check("c9_tz", Tz, R_LOAD);
    repeat (3) tick();                                     // cycle 12
    check("c12_halted", {3'b000, halted}, 4'h0);
    tick();                                                // cycle 13
    check("c13_halted", {3'b000, halted}, 4'h1);
    check("c13_busy", {3'b000, busy}, 4'h0);
    check("c13_req", {3'b000, mem_req}, 4'h0);

    // Four-cycle ack delay: each instruction takes 7 cycles
    clear_prog();
    prog[0] = 8'h00; prog[1] = 8'h15; prog[2] = 8'hF0;
    ack_delay = 4;
    start = 1'b1; tick(); start = 1'b0;                    // cycle 1
    check("d1_req", {3'b000, mem_req}, 4'h1);
    repeat (3) tick();                                     // cycle 4
    check("d4_req", {3'b000, mem_req}, 4'h1);
    check("d4_addr", mem_addr, 4'h0);
    tick();                                                // cycle 5 (ack)
    check("d5_req", {3'b000, mem_req}, 4'h1);
    tick();                                                // cycle 6
    check("d6_req", {3'b000, mem_req}, 4'h0);
    tick();                                                // cycle 7
    check("d7_busy", {3'b000, busy}, 4'h1);
    tick();                                                // cycle 8
    check("d8_addr", mem_addr, 4'h1);
    check("d8_req", {3'b000, mem_req}, 4'h1);
    repeat (2) tick();                                     // cycle 10
    start = 1'b1; tick(); start = 1'b0;                    // cycle 11
    check("d11_busy", {3'b000, busy}, 4'h1);
    tick();                                                // cycle 12
    check("d12_addr_held", mem_addr, 4'h1);
    check("d12_req", {3'b000, mem_req}, 4'h1);
    repeat (2) tick();                                     // cycle 14
    check("d14_tx", Tx, R_LOAD);
    wait_halted(40);

    // JMP, illegal opcode, wrap 15->0, JZ taken / not taken
    clear_prog();
    prog[0] = 8'h75; prog[5] = 8'h7E; prog[14] = 8'hB0; prog[15] = 8'h00;
    prog[2] = 8'h8A; prog[3] = 8'hF0;
    ack_delay = 0;
    start = 1'b1; tick(); start = 1'b0;                    // cycle 1
    check("j1_addr", mem_addr, 4'h0);
    repeat (3) tick();                                     // cycle 4
    check("jmp5_addr", mem_addr, 4'h5);
    repeat (3) tick();                                     // cycle 7
    check("jmpE_addr", mem_addr, 4'hE);
    tick();                                                // cycle 8
    check("ill_pre", {3'b000, illegal}, 4'h0);
    tick();                                                // cycle 9
    check("ill_pulse", {3'b000, illegal}, 4'h1);
    check_hold("ill");
    tick();                                                // cycle 10
    check("ill_post", {3'b000, illegal}, 4'h0);
    check("ill_pc_inc", mem_addr, 4'hF);
    prog[0] = 8'h82;
    repeat (3) tick();                                     // cycle 13
    check("wrap_addr", mem_addr, 4'h0);
    repeat (2) tick();                                     // cycle 15 (JZ exec)
    ula_zero = 1'b1;
    tick();                                                // cycle 16
    ula_zero = 1'b0;
    check("jz_taken", mem_addr, 4'h2);
    repeat (3) tick();                                     // cycle 19
    check("jz_not_taken", mem_addr, 4'h3);
    wait_halted(20);

    // Reset in the middle of a stalled fetch, with start asserted alongside
    clear_prog();
    prog[1] = 8'h13;
    start = 1'b1; tick(); start = 1'b0;                    // cycle 1
    repeat (2) tick();                                     // cycle 3
    ack_delay = 4;
    tick();                                                // cycle 4
    check("r4_addr", mem_addr, 4'h1);
    check("r4_req", {3'b000, mem_req}, 4'h1);
    tick();                                                // cycle 5
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("ar_req", {3'b000, mem_req}, 4'h0);
    check("ar_addr", mem_addr, 4'h0);
    check("ar_busy", {3'b000, busy}, 4'h0);
    check("ar_tx", Tx, R_HOLD);
    tick();
    check("ar_start_busy", {3'b000, busy}, 4'h0);
    check("ar_start_req", {3'b000, mem_req}, 4'h0);
    rst_n = 1'b1;
    start = 1'b0;
    ack_delay = 0;
    tick();
    check("post_rst_busy", {3'b000, busy}, 4'h0);
    check("post_rst_halted", {3'b000, halted}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
